// File: rtl/hilo_unit.sv
// HI/LO register unit: holds the {HI,LO} pair, merges mul/div results and stalls hazards.
// Optional macro HILO_BYPASS_EN forwards the value being committed straight onto hi_out/lo_out.
module hilo_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_start,
    input  logic [1:0]            op_mode,
    input  logic                  res_valid,
    input  logic [2*DATA_W-1:0]   res_data,
    input  logic                  mthi_we,
    input  logic                  mtlo_we,
    input  logic [DATA_W-1:0]     mt_data,
    input  logic                  rd_req,
    input  logic                  flush,
    output logic [DATA_W-1:0]     hi_out,
    output logic [DATA_W-1:0]     lo_out,
    output logic                  busy,
    output logic                  stall,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        ACC  = 2'b10
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [DATA_W-1:0]     hi_q;
    logic [DATA_W-1:0]     lo_q;
    logic [2*DATA_W-1:0]   acc_buf;
    logic [1:0]            mode_q;
    logic                  err_q;
    logic                  is_acc;
    logic                  ovw_commit;
    logic                  acc_capture;
    logic                  stall_raw;
    logic [2*DATA_W-1:0]   pair_q;
    logic [2*DATA_W-1:0]   acc_result;

    // Mode 11 is reserved and behaves like a plain overwrite.
    assign is_acc      = (mode_q == 2'b01) || (mode_q == 2'b10);
    assign ovw_commit  = (state == BUSY) && res_valid && !flush && !is_acc;
    assign acc_capture = (state == BUSY) && res_valid && !flush && is_acc;
    assign pair_q      = {hi_q, lo_q};
    assign acc_result  = (mode_q == 2'b10) ? (pair_q - acc_buf) : (pair_q + acc_buf);
    assign stall_raw   = (rd_req | mthi_we | mtlo_we) & (state != IDLE);
    assign busy        = (state != IDLE);
    assign err         = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (op_start) state_nx = BUSY;
            BUSY: begin
                if (flush)              state_nx = IDLE;
                else if (res_valid)     state_nx = is_acc ? ACC : IDLE;
            end
            ACC:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // MT writes only land in IDLE; anywhere else they are stalled and re-presented.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q    <= '0;
            lo_q    <= '0;
            acc_buf <= '0;
            mode_q  <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mthi_we)   hi_q   <= mt_data;
                    if (mtlo_we)   lo_q   <= mt_data;
                    if (op_start)  mode_q <= op_mode;
                    if (res_valid) err_q  <= 1'b1;
                end
                BUSY: begin
                    if (op_start)         err_q        <= 1'b1;
                    if (ovw_commit)       {hi_q, lo_q} <= res_data;
                    else if (acc_capture) acc_buf      <= res_data;
                end
                ACC: begin
                    {hi_q, lo_q} <= acc_result;
                    if (op_start) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef HILO_BYPASS_EN
    // Forward the value that commits at the next edge; the ACC write is not forwarded.
    always_comb begin
        hi_out = hi_q;
        lo_out = lo_q;
        if (reset) begin
            if (state == IDLE) begin
                if (mthi_we) hi_out = mt_data;
                if (mtlo_we) lo_out = mt_data;
            end else if (ovw_commit) begin
                {hi_out, lo_out} = res_data;
            end
        end
    end

    assign stall = stall_raw & ~ovw_commit;
`else
    assign hi_out = hi_q;
    assign lo_out = lo_q;
    assign stall  = stall_raw;
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: randomized mul/div traffic against an arithmetic {HI,LO} model.
module tb_hilo_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           op_start;
    logic [1:0]     op_mode;
    logic           res_valid;
    logic [2*W-1:0] res_data;
    logic           mthi_we;
    logic           mtlo_we;
    logic [W-1:0]   mt_data;
    logic           rd_req;
    logic           flush;
    logic [W-1:0]   hi_out;
    logic [W-1:0]   lo_out;
    logic           busy;
    logic           stall;
    logic           err;

    int             errors = 0;
    int             checks = 0;
    logic [2*W-1:0] m_pair;

    hilo_unit #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset), .op_start(op_start), .op_mode(op_mode),
        .res_valid(res_valid), .res_data(res_data), .mthi_we(mthi_we),
        .mtlo_we(mtlo_we), .mt_data(mt_data), .rd_req(rd_req), .flush(flush),
        .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    // What the pair becomes once a result of the given mode has been merged.
    function automatic logic [2*W-1:0] model_result(input logic [1:0] mode,
                                                    input logic [2*W-1:0] pair,
                                                    input logic [2*W-1:0] res);
        if (mode == 2'b01)      return pair + res;
        else if (mode == 2'b10) return pair - res;
        else                    return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        op_start = 0; op_mode = 0; res_valid = 0; res_data = '0;
        mthi_we = 0; mtlo_we = 0; mt_data = '0; rd_req = 0; flush = 0;
    endtask

    task automatic load_pair(input logic [2*W-1:0] p);
        mthi_we = 1; mt_data = p[2*W-1:W]; tick();
        mthi_we = 0; mtlo_we = 1; mt_data = p[W-1:0]; tick();
        mtlo_we = 0;
        m_pair = p;
    endtask

    task automatic test_reset();
        reset = 0;
        idle_inputs();
        repeat (2) tick();
        checks++; if ({hi_out, lo_out} !== 64'h0) begin errors++; $display("[TB] FAIL reset_pair: got %h expected 0", {hi_out, lo_out}); end
        checks++; if ({busy, stall, err} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {busy, stall, err}); end
        #2 reset = 1;
        tick();
        m_pair = '0;
        checks++; if ({hi_out, lo_out, busy, err} !== 66'h0) begin errors++; $display("[TB] FAIL reset_release: got %h expected 0", {hi_out, lo_out, busy, err}); end
    endtask

    task automatic test_mt();
        logic [W-1:0] d;
        mthi_we = 1; mt_data = 32'h1234_5678; tick();
        mthi_we = 0; mtlo_we = 1; mt_data = 32'h9ABC_DEF0; tick();
        mtlo_we = 0;
        m_pair = 64'h12345678_9ABCDEF0;
        checks++; if ({hi_out, lo_out} !== m_pair) begin errors++; $display("[TB] FAIL mt_fixed: got %h expected %h", {hi_out, lo_out}, m_pair); end
        checks++; if ({busy, err} !== 2'b00) begin errors++; $display("[TB] FAIL mt_flags: got %b expected 00", {busy, err}); end
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            mthi_we = $urandom_range(0, 1);
            mtlo_we = $urandom_range(0, 1);
            mt_data = d;
            if (mthi_we) m_pair[2*W-1:W] = d;
            if (mtlo_we) m_pair[W-1:0]   = d;
            tick();
            checks++; if ({hi_out, lo_out} !== m_pair) begin errors++; $display("[TB] FAIL mt_rand%0d: got %h expected %h", i, {hi_out, lo_out}, m_pair); end
        end
        idle_inputs();
    endtask

    task automatic test_overwrite();
        logic [2*W-1:0] old;
        old = m_pair;
        rd_req = 1; op_start = 1; op_mode = 2'b00;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL ow_idle_stall: got %b expected 0", stall); end
        tick();
        op_start = 0;
        for (int i = 0; i < 2; i++) begin
            checks++; if ({busy, stall} !== 2'b11) begin errors++; $display("[TB] FAIL ow_wait%0d busy/stall: got %b expected 11", i, {busy, stall}); end
            tick();
        end
        res_valid = 1; res_data = 64'h00000001_FFFFFFFE;
        #1;
`ifdef HILO_BYPASS_EN
        checks++; if ({hi_out, stall} !== {32'h1, 1'b0}) begin errors++; $display("[TB] FAIL ow_bypass: got %h/%b expected 00000001/0", hi_out, stall); end
`else
        checks++; if ({stall, hi_out, lo_out} !== {1'b1, old}) begin errors++; $display("[TB] FAIL ow_res_cycle: got %h expected %h", {stall, hi_out, lo_out}, {1'b1, old}); end
`endif
        tick();
        res_valid = 0;
        m_pair = 64'h00000001_FFFFFFFE;
        checks++; if ({hi_out, lo_out} !== m_pair) begin errors++; $display("[TB] FAIL ow_pair: got %h expected %h", {hi_out, lo_out}, m_pair); end
        checks++; if ({busy, stall, err} !== 3'b000) begin errors++; $display("[TB] FAIL ow_after: got %b expected 000", {busy, stall, err}); end
        idle_inputs();
    endtask

    task automatic test_accumulate();
        logic [2*W-1:0] res;
        logic [1:0]     mode;
        int             dly;
        load_pair(64'h00000000_FFFFFFFF);
        op_start = 1; op_mode = 2'b01; tick();
        op_start = 0; res_valid = 1; res_data = 64'h1;
        mthi_we = 1; mt_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL acc_mt_stall: got %b expected 1", stall); end
        tick();
        idle_inputs();
        checks++; if ({busy, hi_out, lo_out} !== {1'b1, m_pair}) begin errors++; $display("[TB] FAIL acc_mid: got %h expected %h", {busy, hi_out, lo_out}, {1'b1, m_pair}); end
        tick();
        checks++; if ({hi_out, lo_out} !== 64'h00000001_00000000) begin errors++; $display("[TB] FAIL acc_carry: got %h expected 0000000100000000", {hi_out, lo_out}); end
        m_pair = 64'h00000001_00000000;
        load_pair(64'h0);
        op_start = 1; op_mode = 2'b10; tick();
        op_start = 0; res_valid = 1; res_data = 64'h1; tick();
        res_valid = 0; tick();
        checks++; if ({hi_out, lo_out} !== 64'hFFFFFFFF_FFFFFFFF) begin errors++; $display("[TB] FAIL sub_wrap: got %h expected ffffffffffffffff", {hi_out, lo_out}); end
        m_pair = 64'hFFFFFFFF_FFFFFFFF;
        for (int i = 0; i < 10; i++) begin
            mode = 2'($urandom_range(0, 3));
            dly  = $urandom_range(0, 3);
            res  = {$urandom, $urandom};
            op_start = 1; op_mode = mode; tick();
            op_start = 0;
            repeat (dly) tick();
            res_valid = 1; res_data = res; tick();
            res_valid = 0;
            if (mode == 2'b01 || mode == 2'b10) begin
                checks++; if ({busy, hi_out, lo_out} !== {1'b1, m_pair}) begin errors++; $display("[TB] FAIL rand%0d_mid: got %h expected %h", i, {busy, hi_out, lo_out}, {1'b1, m_pair}); end
                tick();
            end
            m_pair = model_result(mode, m_pair, res);
            checks++; if ({busy, hi_out, lo_out} !== {1'b0, m_pair}) begin errors++; $display("[TB] FAIL rand%0d mode %0d: got %h expected %h", i, mode, {busy, hi_out, lo_out}, {1'b0, m_pair}); end
        end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL acc_err: got %b expected 0", err); end
    endtask

    task automatic test_flush();
        op_start = 1; op_mode = 2'($urandom_range(0, 3)); tick();
        op_start = 0; tick();
        res_valid = 1; flush = 1; res_data = {$urandom, $urandom}; tick();
        idle_inputs();
        checks++; if ({busy, err, hi_out, lo_out} !== {2'b00, m_pair}) begin errors++; $display("[TB] FAIL flush_busy: got %h expected %h", {busy, err, hi_out, lo_out}, {2'b00, m_pair}); end
        op_start = 1; op_mode = 2'b01; tick();
        op_start = 0; res_valid = 1; res_data = {$urandom, $urandom}; tick();
        m_pair = m_pair + res_data;
        res_valid = 0; flush = 1; tick();
        flush = 0;
        checks++; if ({busy, hi_out, lo_out} !== {1'b0, m_pair}) begin errors++; $display("[TB] FAIL flush_acc: got %h expected %h", {busy, hi_out, lo_out}, {1'b0, m_pair}); end
    endtask

    task automatic test_err_idle();
        res_valid = 1; res_data = {$urandom, $urandom}; tick();
        res_valid = 0;
        checks++; if ({err, hi_out, lo_out} !== {1'b1, m_pair}) begin errors++; $display("[TB] FAIL err_idle: got %h expected %h", {err, hi_out, lo_out}, {1'b1, m_pair}); end
        repeat (3) tick();
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky: got %b expected 1", err); end
    endtask

    task automatic test_reset_mid_busy();
        load_pair({$urandom, $urandom} | 64'h1);
        op_start = 1; op_mode = 2'b00; tick();
        op_start = 0; rd_req = 1;
        #1;
        checks++; if ({busy, stall} !== 2'b11) begin errors++; $display("[TB] FAIL rst_pre: got %b expected 11", {busy, stall}); end
        #1 reset = 0;
        #1;
        checks++; if ({hi_out, lo_out, busy, stall, err} !== 67'h0) begin errors++; $display("[TB] FAIL rst_async: got %h expected 0", {hi_out, lo_out, busy, stall, err}); end
        #2 reset = 1;
        idle_inputs();
        m_pair = '0;
        tick();
        checks++; if ({hi_out, lo_out, busy, err} !== 66'h0) begin errors++; $display("[TB] FAIL rst_after: got %h expected 0", {hi_out, lo_out, busy, err}); end
    endtask

    task automatic test_err_busy();
        logic [2*W-1:0] res;
        res = {$urandom, $urandom};
        op_start = 1; op_mode = 2'b00; tick();
        op_mode = 2'b10; tick();
        op_start = 0;
        checks++; if ({busy, err, hi_out, lo_out} !== {2'b11, m_pair}) begin errors++; $display("[TB] FAIL err_busy: got %h expected %h", {busy, err, hi_out, lo_out}, {2'b11, m_pair}); end
        res_valid = 1; res_data = res; tick();
        res_valid = 0;
        m_pair = model_result(2'b00, m_pair, res);
        checks++; if ({busy, err, hi_out, lo_out} !== {2'b01, m_pair}) begin errors++; $display("[TB] FAIL err_mode_kept: got %h expected %h", {busy, err, hi_out, lo_out}, {2'b01, m_pair}); end
    endtask

    initial begin
        test_reset();
        test_mt();
        test_overwrite();
        test_accumulate();
        test_flush();
        test_err_idle();
        test_reset_mid_busy();
        test_err_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
